// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and default constants for the boot loader
package boot_pkg;

  localparam int         BAUD_DIV_DEF  = 434;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // framing FSM states
  typedef enum logic [2:0] {
    SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR
  } boot_state_t;

  // serial receiver states
  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_BITS, RX_STOP
  } rx_state_t;

endpackage

// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - instruction-memory write port
interface boot_loader_if #(
  parameter int AW = 10
);
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          we;

  modport master (output addr, output wdata, output we);
  modport slave  (input addr, input wdata, input we);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with synchroniser and glitch rejection
module uart_rx
  import boot_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int            CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  logic          rx_meta, rx_sync, rx_prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // two-flop synchroniser plus a delayed copy to spot the falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // bit timer and shift register; byte_valid pulses on the stop-bit sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            // a line that is high again mid start-bit was only a glitch
            state   <= rx_sync ? RX_IDLE : RX_BITS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_BITS: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt        <= '0;
            state      <= RX_IDLE;
            byte_valid <= 1'b1;
            byte_data  <= shift;
            frame_err  <= ~rx_sync;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - receives a checksummed image over serial and writes it to instruction memory
module boot_loader
  import boot_pkg::*;
#(
  parameter int         BAUD_DIV  = BAUD_DIV_DEF,
  parameter int         IMEM_AW   = 10,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  boot_loader_if.master        imem,
  output logic                 cpu_rst_n,
  output logic                 boot_done,
  output logic                 boot_err
);

  // word count is one bit wider than the address so a full-depth image fits
  localparam int          CW    = IMEM_AW + 1;
  localparam int unsigned DEPTH = 2 ** IMEM_AW;

  logic        byte_valid, frame_err;
  logic [7:0]  byte_data;

  boot_state_t state, next_state;
  logic [7:0]  len_lo;
  logic [CW-1:0] len_q;
  logic [CW-1:0] wcnt;
  logic [1:0]  bidx;
  logic [7:0]  csum;
  logic [23:0] wbuf;
  logic        err_q;

  logic [15:0] len_full;
  logic        len_bad;
  logic        last_write;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (RX),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign len_full   = {byte_data, len_lo};
  assign len_bad    = (len_full == 16'd0) || (32'(len_full) > DEPTH);
  // the final write strobe is still issued while in DATA; CSUM follows it
  assign last_write = imem.we && (wcnt == len_q);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SYNC;
    else     state <= next_state;
  end

  // next-state logic, advancing only on received bytes
  always_comb begin
    next_state = state;
    case (state)
      SYNC: if (byte_valid && !frame_err && byte_data == SYNC_BYTE) next_state = LEN0;
      LEN0: if (byte_valid) next_state = frame_err ? ERR : LEN1;
      LEN1: if (byte_valid) next_state = (frame_err || len_bad) ? ERR : DATA;
      DATA: begin
        if (byte_valid && frame_err) next_state = ERR;
        else if (last_write)         next_state = CSUM;
      end
      CSUM: if (byte_valid) next_state = (!frame_err && byte_data == csum) ? DONE : ERR;
      DONE: next_state = DONE;
      ERR:  next_state = SYNC;
      default: next_state = SYNC;
    endcase
  end

  // status outputs decoded from state; the error flag outlives the ERR state
  always_comb begin
    cpu_rst_n = (state == DONE);
    boot_done = (state == DONE);
    boot_err  = err_q;
  end

  // length, word assembly, checksum and memory write strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo     <= '0;
      len_q      <= '0;
      wcnt       <= '0;
      bidx       <= '0;
      csum       <= '0;
      wbuf       <= '0;
      err_q      <= 1'b0;
      imem.addr  <= '0;
      imem.wdata <= '0;
      imem.we    <= 1'b0;
    end else begin
      imem.we <= 1'b0;
      if (next_state == ERR)                       err_q <= 1'b1;
      else if (state == SYNC && next_state == LEN0) err_q <= 1'b0;
      if (byte_valid && !frame_err) begin
        case (state)
          LEN0: len_lo <= byte_data;
          LEN1: begin
            len_q <= len_full[CW-1:0];
            wcnt  <= '0;
            bidx  <= '0;
            csum  <= '0;
          end
          DATA: begin
            wbuf <= {byte_data, wbuf[23:8]};
            csum <= csum ^ byte_data;
            bidx <= bidx + 1'b1;
            if (bidx == 2'd3) begin
              imem.we    <= 1'b1;
              imem.addr  <= wcnt[IMEM_AW-1:0];
              imem.wdata <= {byte_data, wbuf};
              wcnt       <= wcnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader
module tb_boot_loader;

  localparam int BD = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic cpu_rst_n, boot_done, boot_err;

  int compared   = 0;
  int mismatched = 0;

  boot_loader_if #(.AW(AW)) imem ();

  boot_loader #(.BAUD_DIV(BD), .IMEM_AW(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (rx),
    .imem      (imem),
    .cpu_rst_n (cpu_rst_n),
    .boot_done (boot_done),
    .boot_err  (boot_err)
  );

  always #5 clk = ~clk;

  // reference: expected writes as {addr, word}, processed byte by byte
  logic [35:0] exp_q[$];
  logic [35:0] act_q[$];
  int          m_phase;   // 0 hunt, 1 len lo, 2 len hi, 3 payload, 4 checksum, 5 accepted
  int          m_len, m_cnt, m_nbytes;
  logic [7:0]  m_cs;
  logic [7:0]  m_bytes[4];
  bit          m_done, m_err;

  always @(negedge clk) if (imem.we === 1'b1) act_q.push_back({imem.addr, imem.wdata});

  task automatic model_reset();
    m_phase = 0; m_len = 0; m_cnt = 0; m_nbytes = 0; m_cs = 8'h00;
    m_done = 1'b0; m_err = 1'b0;
    exp_q.delete(); act_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ferr);
    if (m_phase == 0) begin
      if (!ferr && b == 8'hA5) begin m_phase = 1; m_err = 1'b0; end
    end else if (m_phase == 5) begin
    end else if (ferr) begin
      m_phase = 0; m_err = 1'b1;
    end else if (m_phase == 1) begin
      m_len = b; m_phase = 2;
    end else if (m_phase == 2) begin
      m_len = m_len + 256 * b;
      if (m_len == 0 || m_len > (1 << AW)) begin m_phase = 0; m_err = 1'b1; end
      else begin m_phase = 3; m_cnt = 0; m_nbytes = 0; m_cs = 8'h00; end
    end else if (m_phase == 3) begin
      m_bytes[m_nbytes] = b;
      m_cs = m_cs ^ b;
      m_nbytes++;
      if (m_nbytes == 4) begin
        exp_q.push_back({4'(m_cnt), m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
        m_nbytes = 0;
        m_cnt++;
        if (m_cnt == m_len) m_phase = 4;
      end
    end else begin
      if (b == m_cs) begin m_phase = 5; m_done = 1'b1; end
      else begin m_phase = 0; m_err = 1'b1; end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk); #1 rx = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (BD) @(posedge clk);
    end
    #1 rx = stop;
    repeat (BD) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    model_byte(b, !stop);
  endtask

  task automatic send_frame(input int len, input logic [7:0] data[$], input bit corrupt, input bit with_sync);
    logic [7:0] cs;
    logic [15:0] l16;
    cs  = 8'h00;
    l16 = 16'(len);
    if (with_sync) send_byte(8'hA5, 1'b1);
    send_byte(l16[7:0], 1'b1);
    send_byte(l16[15:8], 1'b1);
    foreach (data[i]) begin
      send_byte(data[i], 1'b1);
      cs = cs ^ data[i];
    end
    send_byte(cs ^ {7'd0, corrupt}, 1'b1);
  endtask

  task automatic do_reset();
    #3 rst = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    compared++;
    if ({imem.addr, imem.wdata, imem.we} !== 37'd0) begin
      mismatched++;
      $display("FAIL reset.imem actual=%h/%h/%b required=0/0/0", imem.addr, imem.wdata, imem.we);
    end
    compared++;
    if ({cpu_rst_n, boot_done, boot_err} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset.status actual=%b required=000", {cpu_rst_n, boot_done, boot_err});
    end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #2;
  endtask

  task automatic test_good_frame();
    logic [7:0] d[$];
    d = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame(2, d, 1'b0, 1'b1);
    compared++;
    if (act_q.size() != 2) begin
      mismatched++;
      $display("FAIL good.write_count actual=%0d required=2", act_q.size());
    end
    if (act_q.size() >= 2) begin
      compared++;
      if (act_q[0] !== {4'd0, 32'h12345678}) begin
        mismatched++; $display("FAIL good.write0 actual=%h required=%h", act_q[0], {4'd0, 32'h12345678});
      end
      compared++;
      if (act_q[1] !== {4'd1, 32'hDEADBEEF}) begin
        mismatched++; $display("FAIL good.write1 actual=%h required=%h", act_q[1], {4'd1, 32'hDEADBEEF});
      end
    end
    compared++;
    if ({boot_done, cpu_rst_n, boot_err} !== 3'b110) begin
      mismatched++; $display("FAIL good.status actual=%b required=110", {boot_done, cpu_rst_n, boot_err});
    end
    send_frame(2, d, 1'b1, 1'b1);
    compared++;
    if (act_q.size() != 2 || {boot_done, cpu_rst_n, boot_err} !== 3'b110) begin
      mismatched++;
      $display("FAIL good.ignored_after_done actual=%0d/%b required=2/110", act_q.size(), {boot_done, cpu_rst_n, boot_err});
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] d[$];
    d = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    send_frame(2, d, 1'b1, 1'b1);
    compared++;
    if ({boot_done, cpu_rst_n, boot_err} !== 3'b001) begin
      mismatched++; $display("FAIL bad_csum.status actual=%b required=001", {boot_done, cpu_rst_n, boot_err});
    end
    compared++;
    if (act_q.size() != 2) begin
      mismatched++; $display("FAIL bad_csum.write_count actual=%0d required=2", act_q.size());
    end
    send_byte(8'hA5, 1'b1);
    compared++;
    if (boot_err !== 1'b0) begin
      mismatched++; $display("FAIL bad_csum.err_clear actual=%b required=0", boot_err);
    end
    send_frame(2, d, 1'b0, 1'b0);
    compared++;
    if ({boot_done, cpu_rst_n, boot_err} !== 3'b110) begin
      mismatched++; $display("FAIL bad_csum.resend_status actual=%b required=110", {boot_done, cpu_rst_n, boot_err});
    end
    compared++;
    if (act_q.size() != exp_q.size()) begin
      mismatched++; $display("FAIL bad_csum.model_count actual=%0d required=%0d", act_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      compared++;
      if (act_q[i] !== exp_q[i]) begin
        mismatched++; $display("FAIL bad_csum.write[%0d] actual=%h required=%h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_length_bounds();
    logic [7:0] d[$];
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    compared++;
    if (boot_err !== 1'b1 || act_q.size() != 0) begin
      mismatched++; $display("FAIL len0.reject actual=%b/%0d required=1/0", boot_err, act_q.size());
    end
    send_byte(8'hA5, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h00, 1'b1);
    compared++;
    if (boot_err !== 1'b1 || act_q.size() != 0) begin
      mismatched++; $display("FAIL len17.reject actual=%b/%0d required=1/0", boot_err, act_q.size());
    end
    for (int i = 0; i < 64; i++) d.push_back(8'($urandom));
    send_frame(16, d, 1'b0, 1'b1);
    compared++;
    if ({boot_done, cpu_rst_n, boot_err} !== 3'b110 || act_q.size() != 16) begin
      mismatched++;
      $display("FAIL len16.accept actual=%b/%0d required=110/16", {boot_done, cpu_rst_n, boot_err}, act_q.size());
    end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      compared++;
      if (act_q[i] !== exp_q[i]) begin
        mismatched++; $display("FAIL len16.write[%0d] actual=%h required=%h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_garbage_glitch();
    logic [7:0] d[$];
    do_reset();
    send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b0);
    compared++;
    if ({boot_done, cpu_rst_n, boot_err} !== 3'b000 || act_q.size() != 0) begin
      mismatched++;
      $display("FAIL garbage.ignored actual=%b/%0d required=000/0", {boot_done, cpu_rst_n, boot_err}, act_q.size());
    end
    send_byte(8'hA5, 1'b1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    d = '{8'hC3, 8'h3C, 8'h96, 8'h69};
    send_frame(1, d, 1'b0, 1'b0);
    compared++;
    if ({boot_done, cpu_rst_n, boot_err} !== 3'b110) begin
      mismatched++; $display("FAIL glitch.status actual=%b required=110", {boot_done, cpu_rst_n, boot_err});
    end
    compared++;
    if (act_q.size() != 1 || (act_q.size() == 1 && act_q[0] !== {4'd0, 32'h69963CC3})) begin
      mismatched++; $display("FAIL glitch.write actual=%0d entries required=1 of %h", act_q.size(), {4'd0, 32'h69963CC3});
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1); send_byte(8'h55, 1'b1);
    compared++;
    if ({boot_done, cpu_rst_n, boot_err} !== 3'b001) begin
      mismatched++; $display("FAIL frame_err.status actual=%b required=001", {boot_done, cpu_rst_n, boot_err});
    end
    compared++;
    if (act_q.size() != 1 || (act_q.size() == 1 && act_q[0] !== {4'd0, 32'h04030201})) begin
      mismatched++; $display("FAIL frame_err.writes actual=%0d required=1", act_q.size());
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] d[$];
    do_reset();
    send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1); send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
    send_byte(8'h12, 1'b1);
    compared++;
    if (imem.wdata !== 32'hDDCCBBAA) begin
      mismatched++; $display("FAIL async.pre_wdata actual=%h required=DDCCBBAA", imem.wdata);
    end
    @(negedge clk); #1 rst = 1'b1;
    #1;
    compared++;
    if ({imem.addr, imem.wdata, imem.we, cpu_rst_n, boot_done, boot_err} !== 40'd0) begin
      mismatched++;
      $display("FAIL async.clear actual=%h/%h/%b/%b required=all zero", imem.addr, imem.wdata, imem.we, {cpu_rst_n, boot_done, boot_err});
    end
    do_reset();
    d = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0};
    send_frame(3, d, 1'b0, 1'b1);
    compared++;
    if ({boot_done, cpu_rst_n, boot_err} !== 3'b110 || act_q.size() != 3) begin
      mismatched++;
      $display("FAIL async.fresh actual=%b/%0d required=110/3", {boot_done, cpu_rst_n, boot_err}, act_q.size());
    end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      compared++;
      if (act_q[i] !== exp_q[i]) begin
        mismatched++; $display("FAIL async.write[%0d] actual=%h required=%h", i, act_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d[$];
    logic [7:0] g;
    int len;
    bit corrupt;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, 1'b1);
      end
      len = $urandom_range(1, 6);
      corrupt = ($urandom_range(0, 3) == 0);
      d.delete();
      for (int i = 0; i < 4 * len; i++) d.push_back(8'($urandom));
      send_frame(len, d, corrupt, 1'b1);
      compared++;
      if ({boot_done, cpu_rst_n, boot_err} !== {m_done, m_done, m_err}) begin
        mismatched++;
        $display("FAIL random[%0d].status actual=%b required=%b", it, {boot_done, cpu_rst_n, boot_err}, {m_done, m_done, m_err});
      end
      compared++;
      if (act_q.size() != exp_q.size()) begin
        mismatched++; $display("FAIL random[%0d].write_count actual=%0d required=%0d", it, act_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < act_q.size()) begin
        compared++;
        if (act_q[i] !== exp_q[i]) begin
          mismatched++; $display("FAIL random[%0d].write[%0d] actual=%h required=%h", it, i, act_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_length_bounds();
    test_garbage_glitch();
    test_frame_err();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
